// File: rtl/gbn_tx_scheduler_pkg.sv
// Shared definitions for the go-back-N transmit scheduler: widths, defaults, FSM encoding.
package gbn_tx_scheduler_pkg;

  localparam int unsigned SEQ_W           = 32;
  localparam int unsigned WIN_W           = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 65_000_000;
  localparam int unsigned TIMER_W_DEF     = 27;
  localparam int unsigned MAX_RETRY_DEF   = 8;

  // Encoding is shown on the 7-segment display.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StWaitTx = 2'd2,
    StFinish = 2'd3
  } gbn_state_e;

  function automatic logic [SEQ_W-1:0] seq_max(input logic [SEQ_W-1:0] a,
                                               input logic [SEQ_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gbn_tx_scheduler_if.sv
// Send-request / ACK / packet-done handshake between the scheduler and the TX path.
interface gbn_tx_scheduler_if;
  import gbn_tx_scheduler_pkg::*;

  logic             send_valid;
  logic [SEQ_W-1:0] send_seq;
  logic             retransmit;
  logic             tx_ready;
  logic             packetsent;
  logic             ack_valid;
  logic [SEQ_W-1:0] ack_num;

  modport master (
    output send_valid, send_seq, retransmit,
    input  tx_ready, packetsent, ack_valid, ack_num
  );

  modport slave (
    input  send_valid, send_seq, retransmit,
    output tx_ready, packetsent, ack_valid, ack_num
  );

endinterface

// File: rtl/gbn_tx_scheduler_retx_timer.sv
// Retransmission timer: start (re)loads zero and runs, stop halts; fire at TIMEOUT_CYC-1.
module gbn_tx_scheduler_retx_timer #(
  parameter int unsigned TIMEOUT_CYC = 65_000_000,
  parameter int unsigned TIMER_W     = 27
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_stop,
  output logic o_running,
  output logic o_fire
);

  localparam logic [TIMER_W-1:0] LastCnt = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] r_count;
  logic               r_running;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count   <= '0;
      r_running <= 1'b0;
    end else if (i_start) begin
      r_count   <= '0;
      r_running <= 1'b1;
    end else if (i_stop) begin
      r_running <= 1'b0;
    end else if (r_running) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_running = r_running;
  assign o_fire    = r_running && (r_count == LastCnt);

endmodule

// File: rtl/gbn_tx_scheduler.sv
// Go-back-N TX scheduler: picks the next SN to send, tracks base/nextseq/hwm against the
// window, consumes cumulative ACKs and rewinds to base on retransmission timeout.
module gbn_tx_scheduler
  import gbn_tx_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TIMER_W     = TIMER_W_DEF,
  parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [SEQ_W-1:0]          i_isn,
  input  logic [SEQ_W-1:0]          i_snmax,
  input  logic [WIN_W-1:0]          i_window,
  gbn_tx_scheduler_if.master        io_tx,
  output logic [SEQ_W-1:0]          o_base,
  output logic [SEQ_W-1:0]          o_nextseq,
  output logic                      o_done,
  output logic                      o_abort,
  output logic [1:0]                o_state
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  gbn_state_e        r_state, w_state_d;
  logic [SEQ_W-1:0]  r_base, w_base_d, r_nextseq, w_nextseq_d, r_hwm, w_hwm_d;
  logic [RetryW-1:0] r_retry, w_retry_d;
  logic              r_pending, w_pending_d, r_done, w_done_d, r_abort, w_abort_d;

  logic [WIN_W-1:0]  w_win;
  logic [SEQ_W:0]    w_limit;
  logic              w_can_send, w_send_valid, w_accept, w_ack_ok;
  logic              w_run_eff, w_timeout, w_t_start, w_t_stop, w_t_running, w_t_fire;

  gbn_tx_scheduler_retx_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TIMER_W     (TIMER_W)
  ) u_retx_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_t_start),
    .i_stop    (w_t_stop),
    .o_running (w_t_running),
    .o_fire    (w_t_fire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_base    <= '0;
      r_nextseq <= '0;
      r_hwm     <= '0;
      r_retry   <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_base    <= w_base_d;
      r_nextseq <= w_nextseq_d;
      r_hwm     <= w_hwm_d;
      r_retry   <= w_retry_d;
      r_pending <= w_pending_d;
      r_done    <= w_done_d;
      r_abort   <= w_abort_d;
    end
  end

  always_comb begin
    w_win        = (i_window == '0) ? WIN_W'(1) : i_window;
    w_limit      = {1'b0, r_base} + (SEQ_W+1)'(w_win);
    w_can_send   = (r_nextseq <= i_snmax) && ({1'b0, r_nextseq} < w_limit);
    w_send_valid = (r_state == StRun) && w_can_send;
    w_accept     = w_send_valid && io_tx.tx_ready;
    w_ack_ok     = io_tx.ack_valid && (io_tx.ack_num > r_base) && (io_tx.ack_num <= r_hwm);

    w_state_d   = r_state;
    w_base_d    = r_base;
    w_nextseq_d = r_nextseq;
    w_hwm_d     = r_hwm;
    w_retry_d   = r_retry;
    w_pending_d = r_pending;
    w_done_d    = r_done;
    w_abort_d   = r_abort;
    w_t_start   = 1'b0;
    w_t_stop    = 1'b0;
    w_run_eff   = w_t_running;
    w_timeout   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_base_d    = i_isn;
          w_nextseq_d = i_isn;
          w_hwm_d     = i_isn;
          w_retry_d   = '0;
          w_pending_d = 1'b0;
          w_t_stop    = 1'b1;
          w_state_d   = StRun;
        end
      end
      StRun, StWaitTx: begin
        // An accepted ACK is progress: it restarts the timer and swallows any timeout.
        if (w_ack_ok) begin
          w_base_d    = io_tx.ack_num;
          w_retry_d   = '0;
          w_pending_d = 1'b0;
          w_run_eff   = (io_tx.ack_num < r_hwm);
          w_t_start   = w_run_eff;
          w_t_stop    = !w_run_eff;
          if (io_tx.ack_num > r_nextseq) w_nextseq_d = io_tx.ack_num;
        end
        w_timeout = w_t_fire && !w_ack_ok;

        if (r_state == StRun) begin
          if (w_accept) begin
            w_state_d = StWaitTx;
            if (w_timeout) begin
              w_pending_d = 1'b1;
              w_t_stop    = 1'b1;
            end
          end else if (w_timeout) begin
            w_nextseq_d = r_base;
            w_retry_d   = r_retry + 1'b1;
            w_t_start   = 1'b1;
          end
        end else begin
          if (w_timeout) begin
            w_pending_d = 1'b1;
            w_t_stop    = 1'b1;
          end
          if (io_tx.packetsent) begin
            w_state_d = StRun;
            w_hwm_d   = seq_max(r_hwm, w_nextseq_d + 1'b1);
            if (w_pending_d) begin
              w_nextseq_d = w_base_d;
              w_retry_d   = r_retry + 1'b1;
              w_pending_d = 1'b0;
              w_t_start   = 1'b1;
              w_t_stop    = 1'b0;
            end else begin
              w_nextseq_d = w_nextseq_d + 1'b1;
              if (!w_run_eff) begin
                w_t_start = 1'b1;
                w_t_stop  = 1'b0;
              end
            end
          end
        end

        if (w_base_d > i_snmax) begin
          w_done_d    = 1'b1;
          w_pending_d = 1'b0;
          w_state_d   = StFinish;
          w_t_start   = 1'b0;
          w_t_stop    = 1'b1;
        end else if (w_retry_d >= RetryW'(MAX_RETRY)) begin
          w_abort_d   = 1'b1;
          w_pending_d = 1'b0;
          w_state_d   = StFinish;
          w_t_start   = 1'b0;
          w_t_stop    = 1'b1;
        end
      end
      StFinish: begin
        w_t_stop = 1'b1;
      end
    endcase

    // Dropping enable discards the transfer from any active state.
    if (!i_enable && (r_state != StIdle)) begin
      w_state_d   = StIdle;
      w_base_d    = '0;
      w_nextseq_d = '0;
      w_hwm_d     = '0;
      w_retry_d   = '0;
      w_pending_d = 1'b0;
      w_done_d    = 1'b0;
      w_abort_d   = 1'b0;
      w_t_start   = 1'b0;
      w_t_stop    = 1'b1;
    end
  end

  assign io_tx.send_valid = w_send_valid;
  assign io_tx.send_seq   = r_nextseq;
  assign io_tx.retransmit = w_send_valid && (r_nextseq < r_hwm);
  assign o_base           = r_base;
  assign o_nextseq        = r_nextseq;
  assign o_done           = r_done;
  assign o_abort          = r_abort;
  assign o_state          = r_state;

endmodule
